universal_shift_reg: RTL

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

---
 rtl/universal_shift_pkg.sv | 32 +++
 rtl/shift_step.sv | 49 ++++
 rtl/universal_shift_reg.sv | 110 +++++++++++
 3 files changed

// File: rtl/universal_shift_pkg.sv
// Shared definitions for the universal shift register: operation codes,
// controller state encoding and a helper that classifies the operation codes.
package universal_shift_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_ASR  = 3'b110,
        MODE_RSVD = 3'b111
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    // True for the codes that move bits one position per cycle.
    function automatic logic is_shift_mode(input mode_t m);
        logic r;
        case (m)
            MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR: r = 1'b1;
            default:                                          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/shift_step.sv
// One-bit step of the register: given the current contents, the latched
// operation and the serial fill bit, produce the next contents and the bit
// that leaves the register.
module shift_step
    import universal_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  mode_t            mode,
    input  logic             serial_in,
    output logic [WIDTH-1:0] next_q,
    output logic             out_bit
);

    // Select the single-position move for the latched operation; anything
    // that is not a shift or rotate leaves the contents alone.
    always_comb begin
        next_q  = q;
        out_bit = 1'b0;
        case (mode)
            MODE_SHL: begin
                next_q  = {q[WIDTH-2:0], serial_in};
                out_bit = q[WIDTH-1];
            end
            MODE_SHR: begin
                next_q  = {serial_in, q[WIDTH-1:1]};
                out_bit = q[0];
            end
            MODE_ROL: begin
                next_q  = {q[WIDTH-2:0], q[WIDTH-1]};
                out_bit = q[WIDTH-1];
            end
            MODE_ROR: begin
                next_q  = {q[0], q[WIDTH-1:1]};
                out_bit = q[0];
            end
            MODE_ASR: begin
                next_q  = {q[WIDTH-1], q[WIDTH-1:1]};
                out_bit = q[0];
            end
            default: begin
                next_q  = q;
                out_bit = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: accepts an operation in IDLE, performs loads and
// holds in a single cycle, and walks shifts/rotates one bit per cycle through
// SHIFT before pulsing Done. All outputs come straight from flops.
module universal_shift_reg
    import universal_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             Clk,
    input  logic             Resetn,
    input  logic             Start,
    input  logic [2:0]       Mode,
    input  logic [AMT_W-1:0] Amt,
    input  logic [WIDTH-1:0] Data_in,
    input  logic             Serial_in,
    output logic [WIDTH-1:0] Q,
    output logic             Serial_out,
    output logic             Busy,
    output logic             Done
);

    state_t           state;
    state_t           next_state;
    mode_t            mode_in;
    mode_t            mode_q;
    logic [AMT_W-1:0] count;
    logic [AMT_W-1:0] amt_clamped;
    logic [WIDTH-1:0] step_q;
    logic             step_out;

    shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .q        (Q),
        .mode     (mode_q),
        .serial_in(Serial_in),
        .next_q   (step_q),
        .out_bit  (step_out)
    );

    // Next-state decode: a zero-length shift and all non-shift codes finish
    // immediately, a real shift parks in SHIFT until the counter runs out.
    always_comb begin
        mode_in     = mode_t'(Mode);
        amt_clamped = (Amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : Amt;
        next_state  = state;
        case (state)
            ST_IDLE: begin
                if (Start) begin
                    if (is_shift_mode(mode_in) && (Amt != '0))
                        next_state = ST_SHIFT;
                    else
                        next_state = ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (count == AMT_W'(1))
                    next_state = ST_DONE;
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // State register, with Busy and Done registered from the next state so
    // they line up exactly with SHIFT and DONE.
    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            state <= ST_IDLE;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            state <= next_state;
            Busy  <= (next_state == ST_SHIFT);
            Done  <= (next_state == ST_DONE);
        end
    end

    // Datapath: latch the operation on acceptance, then apply one step per
    // SHIFT cycle while counting down.
    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            Q          <= '0;
            Serial_out <= 1'b0;
            count      <= '0;
            mode_q     <= MODE_HOLD;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        mode_q <= mode_in;
                        if (mode_in == MODE_LOAD)
                            Q <= Data_in;
                        if (is_shift_mode(mode_in) && (Amt != '0))
                            count <= amt_clamped;
                    end
                end
                ST_SHIFT: begin
                    Q          <= step_q;
                    Serial_out <= step_out;
                    count      <= count - AMT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
